// File: rtl/irq_timer_unit_if.sv
// -----------------------------------------------------------------------------
// irq_timer_unit_if
// Memory-mapped register bus between the data-memory decode (master) and the
// interrupt/timer block (slave).
//   bus_sel    master->slave  register block selected
//   bus_wr     master->slave  write strobe, qualified by bus_sel
//   bus_addr   master->slave  byte address, register offset in bits [4:2]
//   bus_wdata  master->slave  write data
//   bus_rdata  slave->master  combinational read data
// -----------------------------------------------------------------------------
interface irq_timer_unit_if;
  logic        bus_sel;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_sel, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_sel, bus_wr, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/irq_timer_unit.sv
// -----------------------------------------------------------------------------
// irq_timer_unit
// Interrupt source stage ahead of csr_unit. Holds a 64-bit machine timer
// (mtime/mtimecmp) and a synchronised external interrupt line, arbitrates
// them (external first) and holds one registered request until trap entry.
//   clk         system clock
//   reset       synchronous, active-high reset
//   bus         register bus (slave modport)
//   ext_irq_in  asynchronous external interrupt pin
//   irq_ack     one-cycle trap-entry pulse from csr_unit
//   interupt    interrupt request to csr_unit (registered)
//   irq_cause   mcause of the pending request (registered)
// Register offsets: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi,
// 4 ctrl {run, ext_en, timer_en}, 5 pending {meip (W1C), mtip (RO)}.
// -----------------------------------------------------------------------------
module irq_timer_unit #(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  irq_timer_unit_if.slave     bus,
  input  logic                ext_irq_in,
  input  logic                irq_ack,
  output logic                interupt,
  output logic [31:0]         irq_cause
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [31:0]     CAUSE_TM = 32'h8000_0007;
  localparam logic [31:0]     CAUSE_EX = 32'h8000_000B;

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_CLR} state_t;

  state_t            r_state, w_state_nxt;
  logic [63:0]       r_mtime, r_mtimecmp;
  logic [PW-1:0]     r_presc;
  logic              r_timer_en, r_ext_en, r_run;
  logic              r_mtip, r_meip;
  logic [SYNC_STAGES-1:0] r_sync;
  logic              r_sync_d;
  logic              r_interupt, w_int_nxt;
  logic [31:0]       r_cause, w_cause_nxt;
  logic              r_src_ext, w_src_ext_nxt;
  logic              w_ack_clr;

  logic [2:0]        w_off;
  logic              w_wr, w_tick, w_edge, w_mtime_wr;
  logic              w_unused_addr;

  assign w_off         = bus.bus_addr[4:2];
  assign w_unused_addr = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};
  assign w_wr          = bus.bus_sel & bus.bus_wr;
  assign w_mtime_wr    = w_wr & ((w_off == 3'd0) | (w_off == 3'd1));
  assign w_tick        = r_run & (r_presc == PRE_MAX);
  assign w_edge        = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // Read mux: unused bits and offsets 6-7 read as zero.
  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_sel) begin
      unique case (w_off)
        3'd0:    bus.bus_rdata = r_mtime[31:0];
        3'd1:    bus.bus_rdata = r_mtime[63:32];
        3'd2:    bus.bus_rdata = r_mtimecmp[31:0];
        3'd3:    bus.bus_rdata = r_mtimecmp[63:32];
        3'd4:    bus.bus_rdata = {29'd0, r_run, r_ext_en, r_timer_en};
        3'd5:    bus.bus_rdata = {30'd0, r_meip, r_mtip};
        default: bus.bus_rdata = '0;
      endcase
    end
  end

  // Timer, compare and control registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_presc    <= '0;
      r_timer_en <= 1'b0;
      r_ext_en   <= 1'b0;
      r_run      <= 1'b0;
      r_mtip     <= 1'b0;
    end else begin
      // A bus write to mtime wins over the tick and restarts the prescaler.
      if (w_mtime_wr) begin
        r_presc <= '0;
        if (w_off == 3'd0) r_mtime[31:0]  <= bus.bus_wdata;
        else               r_mtime[63:32] <= bus.bus_wdata;
      end else if (r_run) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_mtime <= r_mtime + 64'd1;
      end
      if (w_wr && w_off == 3'd2) r_mtimecmp[31:0]  <= bus.bus_wdata;
      if (w_wr && w_off == 3'd3) r_mtimecmp[63:32] <= bus.bus_wdata;
      if (w_wr && w_off == 3'd4) begin
        r_timer_en <= bus.bus_wdata[0];
        r_ext_en   <= bus.bus_wdata[1];
        r_run      <= bus.bus_wdata[2];
      end
      // Level compare on pre-update values.
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  // External line: synchroniser, rising-edge detect, sticky meip.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_meip   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], ext_irq_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      // A new edge outranks a simultaneous clear.
      if (w_edge)
        r_meip <= 1'b1;
      else if ((w_wr && w_off == 3'd5 && bus.bus_wdata[1]) || w_ack_clr)
        r_meip <= 1'b0;
    end
  end

  // Request FSM: state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_interupt <= 1'b0;
      r_cause    <= '0;
      r_src_ext  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_interupt <= w_int_nxt;
      r_cause    <= w_cause_nxt;
      r_src_ext  <= w_src_ext_nxt;
    end
  end

  // NOTE: every signal is given its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_int_nxt     = r_interupt;
    w_cause_nxt   = r_cause;
    w_src_ext_nxt = r_src_ext;
    w_ack_clr     = 1'b0;
    unique case (r_state)
      IDLE, WAIT_CLR: begin
        if (r_meip && r_ext_en) begin
          w_state_nxt   = ASSERT;
          w_int_nxt     = 1'b1;
          w_cause_nxt   = CAUSE_EX;
          w_src_ext_nxt = 1'b1;
        end else if (r_state == IDLE) begin
          if (r_mtip && r_timer_en) begin
            w_state_nxt   = ASSERT;
            w_int_nxt     = 1'b1;
            w_cause_nxt   = CAUSE_TM;
            w_src_ext_nxt = 1'b0;
          end
        end else if (!r_mtip || !r_timer_en) begin
          // A served timer level must drop before it can be requested again.
          w_state_nxt = IDLE;
        end
      end
      ASSERT: begin
        if (irq_ack) begin
          w_int_nxt = 1'b0;
          if (r_src_ext) begin
            w_ack_clr   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_CLR;
          end
        end else if (r_src_ext ? !r_ext_en : !r_timer_en) begin
          w_int_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign interupt  = r_interupt;
  assign irq_cause = r_cause;

endmodule

// File: tb/tb_irq_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_irq_timer_unit
// Directed bench for irq_timer_unit (PRESCALE=1, SYNC_STAGES=2). Inputs change
// 1 ns after a rising edge; outputs and combinational reads are sampled there.
// -----------------------------------------------------------------------------
module tb_irq_timer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_irq_in;
  logic        irq_ack;
  logic        interupt;
  logic [31:0] irq_cause;

  int n_checks = 0;
  int n_fail   = 0;

  irq_timer_unit_if bus_if ();

  irq_timer_unit #(.PRESCALE(1), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .ext_irq_in (ext_irq_in),
    .irq_ack    (irq_ack),
    .interupt   (interupt),
    .irq_cause  (irq_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write lands on the next rising edge; returns 1 ns after it.
  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    bus_if.bus_sel   = 1'b1;
    bus_if.bus_wr    = 1'b1;
    bus_if.bus_addr  = {27'd0, off, 2'b00};
    bus_if.bus_wdata = data;
    tick();
    bus_if.bus_sel   = 1'b0;
    bus_if.bus_wr    = 1'b0;
  endtask

  // Combinational read within the current cycle; consumes no clock edge.
  task automatic rd_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus_if.bus_sel  = 1'b1;
    bus_if.bus_wr   = 1'b0;
    bus_if.bus_addr = {27'd0, off, 2'b00};
    #1;
    d = bus_if.bus_rdata;
    bus_if.bus_sel  = 1'b0;
    check(tag, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ext_irq_in = 1'b0; irq_ack = 1'b0;
    bus_if.bus_sel = 1'b0; bus_if.bus_wr = 1'b0;
    bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state of every offset and the outputs.
    rd_check("rst_mtime_lo", 3'd0, 32'h0);
    rd_check("rst_mtime_hi", 3'd1, 32'h0);
    rd_check("rst_cmp_lo",   3'd2, 32'hFFFF_FFFF);
    rd_check("rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
    rd_check("rst_ctrl",     3'd4, 32'h0);
    rd_check("rst_pending",  3'd5, 32'h0);
    rd_check("rst_off6",     3'd6, 32'h0);
    check("rst_interupt", {63'd0, interupt}, 64'd0);
    check("rst_cause", {32'd0, irq_cause}, 64'd0);

    // Timer interrupt at mtime == 5.
    bus_write(3'd2, 32'd5);
    bus_write(3'd3, 32'd0);
    bus_write(3'd4, 32'h5);
    rd_check("tm_mtime0", 3'd0, 32'd0);
    repeat (5) tick();
    rd_check("tm_mtime5", 3'd0, 32'd5);
    rd_check("tm_mtip_early", 3'd5, 32'h0);
    tick();
    rd_check("tm_mtip_set", 3'd5, 32'h1);
    check("tm_int_early", {63'd0, interupt}, 64'd0);
    tick();
    check("tm_int_set", {63'd0, interupt}, 64'd1);
    check("tm_cause", {32'd0, irq_cause}, 64'h8000_0007);
    ack_pulse();
    check("tm_int_ack", {63'd0, interupt}, 64'd0);
    repeat (3) tick();
    check("tm_int_wait_clr", {63'd0, interupt}, 64'd0);
    check("tm_cause_held", {32'd0, irq_cause}, 64'h8000_0007);
    bus_write(3'd2, 32'hFFFF_FFFF);
    repeat (2) tick();
    rd_check("tm_mtip_clr", 3'd5, 32'h0);
    check("tm_int_after_clr", {63'd0, interupt}, 64'd0);

    // External interrupt latency.
    bus_write(3'd4, 32'h2);
    ext_irq_in = 1'b1;
    tick();
    tick();
    rd_check("ex_meip_early", 3'd5, 32'h0);
    tick();
    rd_check("ex_meip_set", 3'd5, 32'h2);
    check("ex_int_early", {63'd0, interupt}, 64'd0);
    tick();
    check("ex_int_set", {63'd0, interupt}, 64'd1);
    check("ex_cause", {32'd0, irq_cause}, 64'h8000_000B);
    ack_pulse();
    check("ex_int_ack", {63'd0, interupt}, 64'd0);
    rd_check("ex_meip_clr", 3'd5, 32'h0);
    ext_irq_in = 1'b0;

    // Both pending: external first, then timer.
    bus_write(3'd4, 32'h0);
    bus_write(3'd2, 32'h0);
    ext_irq_in = 1'b1;
    repeat (4) tick();
    ext_irq_in = 1'b0;
    rd_check("both_pending", 3'd5, 32'h3);
    bus_write(3'd4, 32'h7);
    check("both_int_early", {63'd0, interupt}, 64'd0);
    tick();
    check("both_int_ext", {63'd0, interupt}, 64'd1);
    check("both_cause_ext", {32'd0, irq_cause}, 64'h8000_000B);
    ack_pulse();
    check("both_int_gap", {63'd0, interupt}, 64'd0);
    rd_check("both_pending_tm", 3'd5, 32'h1);
    tick();
    check("both_int_tm", {63'd0, interupt}, 64'd1);
    check("both_cause_tm", {32'd0, irq_cause}, 64'h8000_0007);
    ack_pulse();
    check("both_int_ack", {63'd0, interupt}, 64'd0);

    // mtime wrap and write-over-tick.
    bus_write(3'd4, 32'h0);
    bus_write(3'd0, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'hFFFF_FFFF);
    rd_check("wr_mtime_lo", 3'd0, 32'hFFFF_FFFF);
    rd_check("wr_mtime_hi", 3'd1, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'h4);
    rd_check("wrap_before", 3'd0, 32'hFFFF_FFFF);
    tick();
    rd_check("wrap_lo", 3'd0, 32'h0);
    rd_check("wrap_hi", 3'd1, 32'h0);
    bus_write(3'd0, 32'h100);
    rd_check("wr_over_tick_lo", 3'd0, 32'h100);
    rd_check("wr_over_tick_hi", 3'd1, 32'h0);
    tick();
    rd_check("tick_after_wr", 3'd0, 32'h101);

    // Reset while a request is active.
    bus_write(3'd4, 32'h5);
    tick();
    check("mid_int_set", {63'd0, interupt}, 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_int", {63'd0, interupt}, 64'd0);
    check("mid_rst_cause", {32'd0, irq_cause}, 64'd0);
    rd_check("mid_rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
    rd_check("mid_rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rd_check("mid_rst_ctrl",   3'd4, 32'h0);
    rd_check("mid_rst_mtime",  3'd0, 32'h0);
    reset = 1'b0;
    ack_pulse();
    tick();
    check("idle_ack_ignored", {63'd0, interupt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
